board_click_decoder: RTL and testbench



---
 rtl/board_click_decoder_pkg.sv | 11 +
 rtl/board_click_decoder_if.sv | 28 ++
 rtl/board_click_decoder_geometry.sv | 26 ++
 rtl/board_click_decoder.sv | 102 ++++++++++
 tb/tb_board_click_decoder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/board_click_decoder_pkg.sv
// board_pkg: shared screen/cell constants, coordinate type and decoder FSM states
package board_pkg;
  localparam int SCREEN_WIDTH = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int CELL_SHIFT = 4;
  localparam int CELL_SIZE = 1 << CELL_SHIFT;
  localparam int BOARD_SIZE_MIN = 2;
  localparam int BOARD_SIZE_MAX = 6;
  typedef logic [11:0] coord_t;
  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, VALID} state_t;
endpackage

// File: rtl/board_click_decoder_if.sv
// board_click_decoder_if: mouse/game inputs and cell result handshake between mouse side (master) and decoder (slave)
// ports: is_game_on, board_size, mouse_xpos/ypos/left, cell_ready -> decoder; cell_valid, cell/block/sub row/col, miss, busy <- decoder
interface board_click_decoder_if;
  import board_pkg::*;
  logic is_game_on;
  logic [2:0] board_size;
  coord_t mouse_xpos;
  coord_t mouse_ypos;
  logic mouse_left;
  logic cell_ready;
  logic cell_valid;
  logic [5:0] cell_col;
  logic [5:0] cell_row;
  logic [2:0] block_col;
  logic [2:0] block_row;
  logic [2:0] sub_col;
  logic [2:0] sub_row;
  logic miss;
  logic busy;
  modport master (
    output is_game_on, board_size, mouse_xpos, mouse_ypos, mouse_left, cell_ready,
    input cell_valid, cell_col, cell_row, block_col, block_row, sub_col, sub_row, miss, busy
  );
  modport slave (
    input is_game_on, board_size, mouse_xpos, mouse_ypos, mouse_left, cell_ready,
    output cell_valid, cell_col, cell_row, block_col, block_row, sub_col, sub_row, miss, busy
  );
endinterface

// File: rtl/board_click_decoder_geometry.sv
// board_geometry: board_size -> centred board origin (x0, y0), extent (w, h) and size_ok; shared with the overlay draw path
// ports: board_size in; x0, y0, w, h, size_ok out (combinational)
module board_geometry
  import board_pkg::*;
#(
  parameter int SCREEN_WIDTH = board_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = board_pkg::SCREEN_HEIGHT,
  parameter int CELL_SHIFT = board_pkg::CELL_SHIFT
) (
  input  logic [2:0] board_size,
  output coord_t     x0,
  output coord_t     y0,
  output coord_t     w,
  output coord_t     h,
  output logic       size_ok
);
  coord_t n;
  always_comb begin
    n = coord_t'(board_size) * coord_t'(board_size);
    w = n << CELL_SHIFT;
    h = w;
    x0 = (coord_t'(SCREEN_WIDTH) - w) >> 1;
    y0 = (coord_t'(SCREEN_HEIGHT) - h) >> 1;
    size_ok = board_size >= 3'(BOARD_SIZE_MIN) && board_size <= 3'(BOARD_SIZE_MAX);
  end
endmodule

// File: rtl/board_click_decoder.sv
// board_click_decoder: turns a left-click at screen coordinates into sudoku cell/block/sub-cell coordinates
// ports: clk, rst (sync, active-high); bus (slave modport) carries mouse inputs, result handshake, miss and busy
module board_click_decoder
  import board_pkg::*;
#(
  parameter int SCREEN_WIDTH = board_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = board_pkg::SCREEN_HEIGHT,
  parameter int CELL_SHIFT = board_pkg::CELL_SHIFT
) (
  input logic clk,
  input logic rst,
  board_click_decoder_if.slave bus
);
  state_t state, state_n;
  logic prev_left, press, game;
  coord_t x_q, y_q, x0, y0, w, h, dx, dy;
  logic [2:0] bs_q, block_col, block_row;
  logic [5:0] bs6, col, row, rc, rr;
  logic size_ok, in_board, valid_q, miss_q;
  board_geometry #(
    .SCREEN_WIDTH(SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .CELL_SHIFT(CELL_SHIFT)
  ) u_geom (
    .board_size(bs_q),
    .x0(x0),
    .y0(y0),
    .w(w),
    .h(h),
    .size_ok(size_ok)
  );
  assign game = bus.is_game_on;
  assign press = bus.mouse_left && !prev_left;
  assign bs6 = {3'b000, bs_q};
  assign dx = x_q - x0;
  assign dy = y_q - y0;
  assign in_board = size_ok && x_q >= x0 && x_q < x0 + w && y_q >= y0 && y_q < y0 + h;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = press && game ? CHECK : IDLE;
      CHECK:   state_n = game && in_board ? DIVIDE : IDLE;
      DIVIDE:  state_n = !game ? IDLE : rc < bs6 && rr < bs6 ? VALID : DIVIDE;
      VALID:   state_n = !game || (valid_q && bus.cell_ready) ? IDLE : VALID;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev_left <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      bs_q <= '0;
      col <= '0;
      row <= '0;
      rc <= '0;
      rr <= '0;
      block_col <= '0;
      block_row <= '0;
      valid_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state <= state_n;
      prev_left <= bus.mouse_left;
      if (state == IDLE && press && game) begin
        x_q <= bus.mouse_xpos;
        y_q <= bus.mouse_ypos;
        bs_q <= bus.board_size;
      end
      if (state == CHECK && state_n == DIVIDE) begin
        col <= 6'(dx >> CELL_SHIFT);
        row <= 6'(dy >> CELL_SHIFT);
        rc <= 6'(dx >> CELL_SHIFT);
        rr <= 6'(dy >> CELL_SHIFT);
        block_col <= '0;
        block_row <= '0;
      end
      // repeated subtraction: quotient fits in 5 steps since N <= 36
      if (state == DIVIDE && rc >= bs6) begin
        rc <= rc - bs6;
        block_col <= block_col + 3'd1;
      end
      if (state == DIVIDE && rr >= bs6) begin
        rr <= rr - bs6;
        block_row <= block_row + 3'd1;
      end
      // valid lags the VALID state by one cycle so it always sees final remainders
      valid_q <= state == VALID && state_n == VALID;
      miss_q <= state == CHECK && game && !in_board;
    end
  end
  assign bus.cell_valid = valid_q;
  assign bus.cell_col = col;
  assign bus.cell_row = row;
  assign bus.block_col = block_col;
  assign bus.block_row = block_row;
  assign bus.sub_col = rc[2:0];
  assign bus.sub_row = rr[2:0];
  assign bus.miss = miss_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_board_click_decoder.sv
// tb_board_click_decoder: directed self-checking bench for board_click_decoder
module tb_board_click_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  board_click_decoder_if bus ();
  board_click_decoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [2:0] bs, input int x, input int y);
    bus.board_size = bs;
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
    bus.mouse_left = 1'b1;
    tick(1);
    bus.mouse_left = 1'b0;
  endtask
  task automatic chk_result(input string tag, input int c, input int r, input int bc, input int br, input int sc, input int sr);
    chk({tag, "_valid"}, {11'b0, bus.cell_valid}, 12'd1);
    chk({tag, "_col"}, {6'b0, bus.cell_col}, 12'(c));
    chk({tag, "_row"}, {6'b0, bus.cell_row}, 12'(r));
    chk({tag, "_bcol"}, {9'b0, bus.block_col}, 12'(bc));
    chk({tag, "_brow"}, {9'b0, bus.block_row}, 12'(br));
    chk({tag, "_scol"}, {9'b0, bus.sub_col}, 12'(sc));
    chk({tag, "_srow"}, {9'b0, bus.sub_row}, 12'(sr));
  endtask
  task automatic chk_miss(input string tag, input logic [2:0] bs, input int x, input int y);
    press(bs, x, y);
    chk({tag, "_miss_e0"}, {11'b0, bus.miss}, 12'd0);
    tick(1);
    chk({tag, "_miss_e1"}, {11'b0, bus.miss}, 12'd1);
    tick(1);
    chk({tag, "_miss_e2"}, {11'b0, bus.miss}, 12'd0);
    chk({tag, "_busy"}, {11'b0, bus.busy}, 12'd0);
    tick(8);
    chk({tag, "_novalid"}, {11'b0, bus.cell_valid}, 12'd0);
  endtask
  initial begin
    bus.is_game_on = 1'b1;
    bus.board_size = 3'd3;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    bus.mouse_left = 1'b0;
    bus.cell_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_valid", {11'b0, bus.cell_valid}, 12'd0);
    chk("rst_busy", {11'b0, bus.busy}, 12'd0);
    chk("rst_miss", {11'b0, bus.miss}, 12'd0);
    chk("rst_col", {6'b0, bus.cell_col}, 12'd0);
    // bs=3: X0=440 Y0=312; (509,440) -> col 4 row 8, k=2, valid at edge 5
    press(3'd3, 509, 440);
    chk("bs3_busy", {11'b0, bus.busy}, 12'd1);
    tick(4);
    chk("bs3_e4_valid", {11'b0, bus.cell_valid}, 12'd0);
    tick(1);
    chk_result("bs3", 4, 8, 1, 2, 1, 2);
    tick(2);
    chk("bs3_hold", {11'b0, bus.cell_valid}, 12'd1);
    bus.cell_ready = 1'b1;
    tick(1);
    chk("bs3_hs_valid", {11'b0, bus.cell_valid}, 12'd0);
    chk("bs3_hs_busy", {11'b0, bus.busy}, 12'd0);
    chk("bs3_hold_col", {6'b0, bus.cell_col}, 12'd4);
    // bs=6: X0=224 Y0=96; (799,671) -> col=row=35, k=5, valid at edge 8 for one cycle
    press(3'd6, 799, 671);
    tick(7);
    chk("bs6_e7_valid", {11'b0, bus.cell_valid}, 12'd0);
    tick(1);
    chk_result("bs6", 35, 35, 5, 5, 5, 5);
    tick(1);
    chk("bs6_one_cycle", {11'b0, bus.cell_valid}, 12'd0);
    chk("bs6_idle", {11'b0, bus.busy}, 12'd0);
    chk_miss("bs6_x800", 3'd6, 800, 300);
    chk_miss("bs6_x223", 3'd6, 223, 300);
    chk_miss("bs1", 3'd1, 512, 384);
    chk_miss("bs7", 3'd7, 512, 384);
    // game off: press ignored entirely
    bus.is_game_on = 1'b0;
    press(3'd3, 509, 440);
    chk("off_busy", {11'b0, bus.busy}, 12'd0);
    tick(1);
    chk("off_miss", {11'b0, bus.miss}, 12'd0);
    tick(6);
    chk("off_valid", {11'b0, bus.cell_valid}, 12'd0);
    chk("off_busy2", {11'b0, bus.busy}, 12'd0);
    bus.is_game_on = 1'b1;
    // bs=2: X0=480 Y0=352 (W=64); top-left cell -> all zeros, k=0, valid at edge 3
    bus.cell_ready = 1'b0;
    press(3'd2, 480, 352);
    tick(2);
    chk("bs2_e2_valid", {11'b0, bus.cell_valid}, 12'd0);
    tick(1);
    chk_result("bs2", 0, 0, 0, 0, 0, 0);
    tick(2);
    press(3'd2, 543, 415);
    tick(7);
    chk_result("bs2_held", 0, 0, 0, 0, 0, 0);
    bus.cell_ready = 1'b1;
    tick(1);
    chk("bs2_hs_valid", {11'b0, bus.cell_valid}, 12'd0);
    chk("bs2_hs_busy", {11'b0, bus.busy}, 12'd0);
    tick(3);
    chk("bs2_no_replay", {11'b0, bus.busy}, 12'd0);
    // held button does not retrigger
    bus.mouse_left = 1'b1;
    bus.board_size = 3'd3;
    tick(1);
    chk("held_first", {11'b0, bus.busy}, 12'd1);
    tick(10);
    chk("held_idle", {11'b0, bus.busy}, 12'd0);
    bus.mouse_left = 1'b0;
    tick(1);
    // reset during DIVIDE drops the pending result
    press(3'd6, 799, 671);
    tick(2);
    chk("rstdiv_busy_before", {11'b0, bus.busy}, 12'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstdiv_busy", {11'b0, bus.busy}, 12'd0);
    chk("rstdiv_valid", {11'b0, bus.cell_valid}, 12'd0);
    chk("rstdiv_col", {6'b0, bus.cell_col}, 12'd0);
    tick(8);
    chk("rstdiv_stays", {11'b0, bus.cell_valid}, 12'd0);
    press(3'd3, 509, 440);
    tick(5);
    chk_result("after_rst", 4, 8, 1, 2, 1, 2);
    tick(1);
    // game off during VALID aborts
    bus.cell_ready = 1'b0;
    press(3'd6, 239, 111);
    tick(3);
    chk_result("abort_pre", 0, 0, 0, 0, 0, 0);
    bus.is_game_on = 1'b0;
    tick(1);
    chk("abort_valid", {11'b0, bus.cell_valid}, 12'd0);
    chk("abort_busy", {11'b0, bus.busy}, 12'd0);
    chk("abort_miss", {11'b0, bus.miss}, 12'd0);
    bus.is_game_on = 1'b1;
    bus.cell_ready = 1'b1;
    // (600,500) with bs=5: X0=312 Y0=184 -> col 18 row 19, blocks 3/3, subs 3/4, k=3
    press(3'd5, 600, 500);
    tick(5);
    chk("after_abort_e5", {11'b0, bus.cell_valid}, 12'd0);
    tick(1);
    chk_result("after_abort", 18, 19, 3, 3, 3, 4);
    tick(1);
    chk("after_abort_done", {11'b0, bus.cell_valid}, 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
